unit_sweep_ctrl: RTL and testbench

// Sequencer that drives the 'unit' datapath through an operand sweep. Walks every
// (A,B) point and resets 'unit' per point. Runs 'unit' for a settle window, then

---
 rtl/unit_sweep_ctrl_if.sv | 31 +++
 rtl/unit_sweep_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_unit_sweep_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/unit_sweep_ctrl_if.sv
// unit_sweep_ctrl_if: operand/control bundle between the sweep sequencer and
// the 'unit' datapath.
//   unit_A/unit_B : operands driven by the sequencer
//   unit_Run      : Run strobe to unit
//   unit_Reset    : active-high Reset to unit
//   Yout/nYout    : unit result and its inverted copy
// Modports: master = sequencer side, slave = unit side.
interface unit_sweep_ctrl_if #(
  parameter int unsigned A_W = 2,
  parameter int unsigned B_W = 2,
  parameter int unsigned Y_W = 8
) ();

  logic [A_W-1:0] unit_A;
  logic [B_W-1:0] unit_B;
  logic           unit_Run;
  logic           unit_Reset;
  logic [Y_W-1:0] Yout;
  logic [Y_W-1:0] nYout;

  modport master (
    output unit_A, unit_B, unit_Run, unit_Reset,
    input  Yout, nYout
  );

  modport slave (
    input  unit_A, unit_B, unit_Run, unit_Reset,
    output Yout, nYout
  );

endinterface

// File: rtl/unit_sweep_ctrl.sv
// unit_sweep_ctrl: walks every (A,B) operand point of the 'unit' datapath,
// resetting it per point, running it for SETTLE_CYC unpaused cycles, then
// capturing Yout, checking nYout == ~Yout and accumulating a 16-bit checksum.
// Ports:
//   clk, nReset         : clock, async active-low reset
//   start               : begin a sweep (honoured in IDLE only)
//   pause               : freeze settle counter and drop unit_Run in RUN
//   unit_bus (master)   : unit_A/unit_B/unit_Run/unit_Reset out, Yout/nYout in
//   busy                : sweep in progress (LOAD/RUN/CAPTURE)
//   done                : 1-cycle pulse when the sweep finishes
//   err                 : sticky complement-check failure, cleared by start
//   cap_valid           : 1-cycle pulse, cap_A/cap_B/cap_Y just updated
//   cap_A/cap_B/cap_Y   : last captured point and its Yout
//   checksum            : sum of captured Yout mod 2^16
module unit_sweep_ctrl #(
  parameter int unsigned SETTLE_CYC = 15,
  parameter int unsigned A_W        = 2,
  parameter int unsigned B_W        = 2,
  parameter int unsigned Y_W        = 8
) (
  input  logic                      clk,
  input  logic                      nReset,
  input  logic                      start,
  input  logic                      pause,
  unit_sweep_ctrl_if.master         unit_bus,
  output logic                      busy,
  output logic                      done,
  output logic                      err,
  output logic                      cap_valid,
  output logic [A_W-1:0]            cap_A,
  output logic [B_W-1:0]            cap_B,
  output logic [Y_W-1:0]            cap_Y,
  output logic [15:0]               checksum
);

  localparam int unsigned IDX_W = A_W + B_W;
  localparam int unsigned CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC);
  localparam int unsigned CS_W  = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   pt_q, pt_d;
  logic [IDX_W-1:0]   pt_nxt;
  logic               last_pt;
  logic               settle_end;

  logic [A_W-1:0]     ua_d;
  logic [B_W-1:0]     ub_d;
  logic               run_d;
  logic               urst_d;
  logic               busy_d;
  logic               done_d;
  logic               err_d;
  logic               cap_valid_d;
  logic [A_W-1:0]     cap_a_d;
  logic [B_W-1:0]     cap_b_d;
  logic [Y_W-1:0]     cap_y_d;
  logic [CS_W-1:0]    cs_d;

  assign pt_nxt     = pt_q + IDX_W'(1);
  assign last_pt    = (pt_q == {IDX_W{1'b1}});
  assign settle_end = (cnt_q == CNT_W'(SETTLE_CYC - 1));

  // State and all registered outputs
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q             <= S_IDLE;
      cnt_q               <= '0;
      pt_q                <= '0;
      unit_bus.unit_A     <= '0;
      unit_bus.unit_B     <= '0;
      unit_bus.unit_Run   <= 1'b0;
      unit_bus.unit_Reset <= 1'b1;
      busy                <= 1'b0;
      done                <= 1'b0;
      err                 <= 1'b0;
      cap_valid           <= 1'b0;
      cap_A               <= '0;
      cap_B               <= '0;
      cap_Y               <= '0;
      checksum            <= '0;
    end else begin
      state_q             <= state_d;
      cnt_q               <= cnt_d;
      pt_q                <= pt_d;
      unit_bus.unit_A     <= ua_d;
      unit_bus.unit_B     <= ub_d;
      unit_bus.unit_Run   <= run_d;
      unit_bus.unit_Reset <= urst_d;
      busy                <= busy_d;
      done                <= done_d;
      err                 <= err_d;
      cap_valid           <= cap_valid_d;
      cap_A               <= cap_a_d;
      cap_B               <= cap_b_d;
      cap_Y               <= cap_y_d;
      checksum            <= cs_d;
    end
  end

  // Next state and next output values; outputs describe the state being entered
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pt_d        = pt_q;
    ua_d        = unit_bus.unit_A;
    ub_d        = unit_bus.unit_B;
    run_d       = 1'b0;
    urst_d      = 1'b1;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    err_d       = err;
    cap_valid_d = 1'b0;
    cap_a_d     = cap_A;
    cap_b_d     = cap_B;
    cap_y_d     = cap_Y;
    cs_d        = checksum;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          pt_d    = '0;
          cnt_d   = '0;
          ua_d    = '0;
          ub_d    = '0;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          cs_d    = '0;
        end
      end

      S_LOAD: begin
        // Run is raised unconditionally on entry; pause acts from the next RUN cycle
        state_d = S_RUN;
        cnt_d   = '0;
        urst_d  = 1'b0;
        run_d   = 1'b1;
        busy_d  = 1'b1;
      end

      S_RUN: begin
        urst_d = 1'b0;
        busy_d = 1'b1;
        if (pause) begin
          run_d = 1'b0;
        end else if (settle_end) begin
          state_d = S_CAPTURE;
          run_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          run_d = 1'b1;
        end
      end

      S_CAPTURE: begin
        cap_valid_d = 1'b1;
        cap_a_d     = unit_bus.unit_A;
        cap_b_d     = unit_bus.unit_B;
        cap_y_d     = unit_bus.Yout;
        cs_d        = checksum + CS_W'(unit_bus.Yout);
        err_d       = err | (unit_bus.nYout != ~unit_bus.Yout);
        if (last_pt) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d = S_LOAD;
          pt_d    = pt_nxt;
          cnt_d   = '0;
          ua_d    = pt_nxt[IDX_W-1:B_W];
          ub_d    = pt_nxt[B_W-1:0];
          busy_d  = 1'b1;
        end
      end

      S_DONE: begin
        // Point index wraps only here
        state_d = S_IDLE;
        pt_d    = '0;
        cnt_d   = '0;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_unit_sweep_ctrl.sv
// tb_unit_sweep_ctrl: directed bench for unit_sweep_ctrl with a stub unit
// (Yout = A*B+1, nYout = ~Yout unless the fault point is forced).
module tb_unit_sweep_ctrl;

  localparam int unsigned SETTLE_CYC = 15;
  localparam int unsigned A_W = 2;
  localparam int unsigned B_W = 2;
  localparam int unsigned Y_W = 8;

  logic             clk;
  logic             nReset;
  logic             start;
  logic             pause;
  logic             busy;
  logic             done;
  logic             err;
  logic             cap_valid;
  logic [A_W-1:0]   cap_A;
  logic [B_W-1:0]   cap_B;
  logic [Y_W-1:0]   cap_Y;
  logic [15:0]      checksum;
  logic             force_bad;
  logic [Y_W-1:0]   stub_y;

  int n_checks;
  int n_errors;

  unit_sweep_ctrl_if #(.A_W(A_W), .B_W(B_W), .Y_W(Y_W)) u_if ();

  unit_sweep_ctrl #(
    .SETTLE_CYC(SETTLE_CYC), .A_W(A_W), .B_W(B_W), .Y_W(Y_W)
  ) dut (
    .clk       (clk),
    .nReset    (nReset),
    .start     (start),
    .pause     (pause),
    .unit_bus  (u_if),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cap_valid (cap_valid),
    .cap_A     (cap_A),
    .cap_B     (cap_B),
    .cap_Y     (cap_Y),
    .checksum  (checksum)
  );

  // Stub unit
  always_comb begin
    stub_y     = Y_W'(u_if.unit_A) * Y_W'(u_if.unit_B) + Y_W'(1);
    u_if.Yout  = stub_y;
    u_if.nYout = (force_bad && u_if.unit_A == 2'd0 && u_if.unit_B == 2'd3) ? stub_y : ~stub_y;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_uA"},    32'(u_if.unit_A), 0);
    check({tag, "_uB"},    32'(u_if.unit_B), 0);
    check({tag, "_uRun"},  32'(u_if.unit_Run), 0);
    check({tag, "_uRst"},  32'(u_if.unit_Reset), 1);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_done"},  32'(done), 0);
    check({tag, "_err"},   32'(err), 0);
    check({tag, "_capv"},  32'(cap_valid), 0);
    check({tag, "_capA"},  32'(cap_A), 0);
    check({tag, "_capB"},  32'(cap_B), 0);
    check({tag, "_capY"},  32'(cap_Y), 0);
    check({tag, "_cs"},    32'(checksum), 0);
  endtask

  // One sweep from a start pulse; k counts edges after the start-sampling edge,
  // and an output set by edge k is reported as cycle k+1.
  task automatic run_sweep(input int plo, input int phi, input int s1, input int s2,
                           input bit bad, input int exp_done);
    int idx;
    int done_k;
    int first_k;
    int ndone;
    idx = 0; done_k = -1; first_k = -1; ndone = 0;
    force_bad = bad;
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_busy", 32'(busy), 1);
    check("start_err_clr", 32'(err), 0);
    check("start_cs_clr", 32'(checksum), 0);
    check("start_uRst", 32'(u_if.unit_Reset), 1);
    for (int k = 1; k < 400; k++) begin
      start = (k == s1) || (k == s2);
      pause = (k >= plo) && (k <= phi);
      step();
      if (cap_valid) begin
        if (first_k < 0) first_k = k;
        if (idx < 16) begin
          check("cap_A", 32'(cap_A), 32'(idx / 4));
          check("cap_B", 32'(cap_B), 32'(idx % 4));
          check("cap_Y", 32'(cap_Y), 32'((idx / 4) * (idx % 4) + 1));
          check("cap_err", 32'(err), 32'(bad && idx >= 3));
        end
        idx++;
      end
      if (plo > 0) begin
        if (k == plo - 1) check("run_before_pause", 32'(u_if.unit_Run), 1);
        if (k == plo)     check("run_pause_first", 32'(u_if.unit_Run), 0);
        if (k == phi)     check("run_pause_last", 32'(u_if.unit_Run), 0);
        if (k == phi + 1) check("run_after_pause", 32'(u_if.unit_Run), 1);
      end
      if (done) begin
        ndone++;
        if (done_k < 0) begin
          done_k = k;
          check("done_busy", 32'(busy), 0);
          check("done_uRst", 32'(u_if.unit_Reset), 1);
          check("done_uRun", 32'(u_if.unit_Run), 0);
        end
      end
      if (done_k >= 0 && k >= done_k + 4) break;
    end
    start = 1'b0;
    pause = 1'b0;
    check("first_cap_cycle", 32'(first_k + 1), SETTLE_CYC + 3);
    check("done_cycle", 32'(done_k + 1), 32'(exp_done));
    check("num_caps", 32'(idx), 16);
    check("num_done", 32'(ndone), 1);
    check("checksum", 32'(checksum), 52);
    check("err_end", 32'(err), 32'(bad));
    check("idle_busy", 32'(busy), 0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    nReset = 1'b0;
    start = 1'b0;
    pause = 1'b0;
    force_bad = 1'b0;

    // Reset values, then release and stay idle
    #12;
    check_reset_vals("rst");
    step();
    nReset = 1'b1;
    step(); step(); step();
    check("idle_after_rst_busy", 32'(busy), 0);
    check("idle_after_rst_uRst", 32'(u_if.unit_Reset), 1);

    // Plain sweep
    run_sweep(-1, -2, -1, -1, 1'b0, 273);

    // Pause 10 cycles in RUN of point (1,1)
    run_sweep(90, 99, -1, -1, 1'b0, 283);

    // Complement fault at (0,3); err holds through idle
    run_sweep(-1, -2, -1, -1, 1'b1, 273);
    step(); step(); step();
    check("err_sticky_idle", 32'(err), 1);

    // Start pulses while busy and while in DONE are ignored (err cleared by start)
    run_sweep(-1, -2, 50, 273, 1'b0, 273);
    step(); step();
    check("no_restart_busy", 32'(busy), 0);

    // Async reset mid-sweep, then a full fresh sweep
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k <= 100; k++) step();
    check("mid_busy", 32'(busy), 1);
    nReset = 1'b0;
    #1;
    check_reset_vals("mid_rst");
    step(); step();
    nReset = 1'b1;
    step(); step();
    check("post_rst_busy", 32'(busy), 0);
    run_sweep(-1, -2, -1, -1, 1'b0, 273);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
